mem_dump_tx: RTL

MEM_DUMP_TX -- requirements
Module: mem_dump_tx

---
 rtl/mem_dump_pkg.sv | 19 +
 rtl/mem_dump_tx_if.sv | 9 +
 rtl/mem_dump_tx.sv | 111 +++++++++++
 3 files changed

// File: rtl/mem_dump_pkg.sv
// mem_dump_pkg: shared widths and FSM state encoding for the memory dump transmitter.
// CKSUM exists only when MEM_DUMP_CKSUM_EN is defined.
package mem_dump_pkg;
   localparam int WORD_W = 16;
   localparam int BYTE_W = 8;
   typedef enum logic [3:0] {
      IDLE,
      RD_ADDR,
      RD_WAIT,
      LOAD,
      TX_REQ,
      TX_ACK,
      TX_DONE,
      NEXT
`ifdef MEM_DUMP_CKSUM_EN
      , CKSUM
`endif
   } state_t;
endpackage

// File: rtl/mem_dump_tx_if.sv
// mem_dump_tx_if: byte handshake between the dump engine (master) and the uart (slave).
interface mem_dump_tx_if;
   import mem_dump_pkg::*;
   logic              start_tx;
   logic              busy_tx;
   logic [BYTE_W-1:0] serial_write;
   modport master (output start_tx, serial_write, input busy_tx);
   modport slave  (input start_tx, serial_write, output busy_tx);
endinterface

// File: rtl/mem_dump_tx.sv
// mem_dump_tx: reads 16-bit words from a synchronous memory and sends them as byte pairs to a uart.
// Define MEM_DUMP_CKSUM_EN to append a modulo-256 byte checksum after the last word.
module mem_dump_tx
   import mem_dump_pkg::*;
#(
   parameter int ADDR_W    = 8,
   parameter bit MSB_FIRST = 1'b1
)(
   input  logic              CLK_UART_i,
   input  logic              RST_i,
   input  logic              start_i,
   input  logic [ADDR_W-1:0] start_addr_i,
   input  logic [ADDR_W:0]   word_count_i,
   output logic [ADDR_W-1:0] mem_addr_o,
   input  logic [WORD_W-1:0] mem_data_i,
   output logic              start_tx_o,
   output logic [BYTE_W-1:0] serial_write_o,
   input  logic              busy_tx_i,
   output logic              busy_o,
   output logic              done_o
);
   state_t            r_state, w_next, w_fin;
   logic [ADDR_W-1:0] r_addr;
   logic [ADDR_W:0]   r_cnt;
   logic [WORD_W-1:0] r_word;
   logic              r_sel, r_done, w_ck, w_done;
   logic [BYTE_W-1:0] w_byte;
`ifdef MEM_DUMP_CKSUM_EN
   logic [BYTE_W-1:0] r_sum;
   logic              r_ck;
   assign w_ck  = r_ck;
   assign w_fin = CKSUM;
`else
   assign w_ck  = 1'b0;
   assign w_fin = IDLE;
`endif
   // r_sel=0 is the first byte of the word; MSB_FIRST picks which half that is
   assign w_byte = (r_sel == MSB_FIRST) ? r_word[BYTE_W-1:0] : r_word[WORD_W-1:BYTE_W];

   always_ff @(posedge CLK_UART_i) begin
      if (RST_i) r_state <= IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (start_i) w_next = (word_count_i == '0) ? w_fin : RD_ADDR;
         RD_ADDR: w_next = RD_WAIT;
         RD_WAIT: w_next = LOAD;
         LOAD:    w_next = TX_REQ;
         TX_REQ:  if (!busy_tx_i) w_next = TX_ACK;
         TX_ACK:  if (busy_tx_i) w_next = TX_DONE;
         TX_DONE: if (!busy_tx_i) w_next = w_ck ? IDLE : r_sel ? NEXT : TX_REQ;
         NEXT:    w_next = (r_cnt == (ADDR_W+1)'(1)) ? w_fin : RD_ADDR;
`ifdef MEM_DUMP_CKSUM_EN
         CKSUM:   w_next = TX_REQ;
`endif
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      start_tx_o = (r_state == TX_REQ) && !busy_tx_i;
      busy_o     = r_state != IDLE;
      done_o     = r_done;
      mem_addr_o = r_addr;
      w_done     = (w_next == IDLE) && ((r_state != IDLE) || (start_i && word_count_i == '0));
`ifdef MEM_DUMP_CKSUM_EN
      serial_write_o = r_ck ? r_sum : w_byte;
`else
      serial_write_o = w_byte;
`endif
   end

   always_ff @(posedge CLK_UART_i) begin
      if (RST_i) begin
         r_addr <= '0;
         r_cnt  <= '0;
         r_word <= '0;
         r_sel  <= 1'b0;
         r_done <= 1'b0;
`ifdef MEM_DUMP_CKSUM_EN
         r_sum  <= '0;
         r_ck   <= 1'b0;
`endif
      end else begin
         r_done <= w_done;
         if (r_state == IDLE && start_i) begin
            r_addr <= start_addr_i;
            r_cnt  <= word_count_i;
            r_sel  <= 1'b0;
`ifdef MEM_DUMP_CKSUM_EN
            r_sum  <= '0;
            r_ck   <= 1'b0;
`endif
         end
         if (r_state == LOAD) r_word <= mem_data_i;
         if (r_state == TX_DONE && !busy_tx_i) r_sel <= ~r_sel;
         if (r_state == NEXT) begin
            r_addr <= r_addr + 1'b1;
            r_cnt  <= r_cnt - 1'b1;
         end
`ifdef MEM_DUMP_CKSUM_EN
         // the checksum byte itself must not feed back while it is on the wire
         if (start_tx_o && !r_ck) r_sum <= r_sum + w_byte;
         if (r_state == CKSUM) r_ck <= 1'b1;
`endif
      end
   end
endmodule
